// File: rtl/adder_4bit_unit_if.sv
// Operand/result bundle for adder_4bit_unit.
// The master drives operands and the capture enable; the slave (the adder)
// returns the combinational and registered results.
// ADDER_4BIT_STATS_EN adds the op_cnt/carry_cnt statistics counters.
interface adder_4bit_unit_if;
    logic [3:0]  a;
    logic [3:0]  b;
    logic        cin;
    logic        en;
    logic [3:0]  sum;
    logic        cout;
    logic [3:0]  sum_q;
    logic        cout_q;
    logic        zero_q;
    logic        ovf_q;
    logic        valid_q;
`ifdef ADDER_4BIT_STATS_EN
    logic [15:0] op_cnt;
    logic [15:0] carry_cnt;
`endif

    modport master (
        output a, b, cin, en,
        input  sum, cout, sum_q, cout_q, zero_q, ovf_q, valid_q
`ifdef ADDER_4BIT_STATS_EN
        , input op_cnt, carry_cnt
`endif
    );

    modport slave (
        input  a, b, cin, en,
        output sum, cout, sum_q, cout_q, zero_q, ovf_q, valid_q
`ifdef ADDER_4BIT_STATS_EN
        , output op_cnt, carry_cnt
`endif
    );
endinterface

// File: rtl/adder_4bit_unit.sv
// 4-bit ripple-carry adder with carry-in/carry-out.
// The combinational result {cout,sum} = a + b + cin is built from four
// explicit full-adder cells. A registered copy with zero/overflow/valid
// flags feeds downstream pipelined stages.
// Optional feature: define ADDER_4BIT_STATS_EN to add the 16-bit capture
// counter (op_cnt) and carry-out capture counter (carry_cnt).
module adder_4bit_unit (
    input  logic               clk,
    input  logic               rst_n,
    adder_4bit_unit_if.slave   bus
);

    // Carry chain: c[0] is the carry-in, c[4] is the carry-out.
    logic [4:0] c;
    logic [3:0] s;
    logic       ovf;

    assign c[0] = bus.cin;

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_fa
            logic p;
            assign p        = bus.a[i] ^ bus.b[i];
            assign s[i]     = p ^ c[i];
            assign c[i+1]   = (bus.a[i] & bus.b[i]) | (c[i] & p);
        end
    endgenerate

    assign bus.sum  = s;
    assign bus.cout = c[4];

    // Signed overflow: both operands share a sign the result does not.
    assign ovf = (bus.a[3] == bus.b[3]) && (s[3] != bus.a[3]);

    // Result register: load on enable, hold otherwise; valid_q marks a capture.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.sum_q   <= 4'h0;
            bus.cout_q  <= 1'b0;
            bus.zero_q  <= 1'b0;
            bus.ovf_q   <= 1'b0;
            bus.valid_q <= 1'b0;
        end else begin
            bus.valid_q <= bus.en;
            if (bus.en) begin
                bus.sum_q  <= s;
                bus.cout_q <= c[4];
                bus.zero_q <= (s == 4'h0);
                bus.ovf_q  <= ovf;
            end
        end
    end

`ifdef ADDER_4BIT_STATS_EN
    // Statistics: count every capture and every capture that carried out; both wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.op_cnt    <= 16'h0000;
            bus.carry_cnt <= 16'h0000;
        end else if (bus.en) begin
            bus.op_cnt <= bus.op_cnt + 16'h0001;
            if (c[4]) begin
                bus.carry_cnt <= bus.carry_cnt + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_adder_4bit_unit.sv
// Directed self-checking bench for adder_4bit_unit.
// Inputs change on the falling edge; outputs are sampled #1 after the
// rising edge (registered) or #1 after driving (combinational).
module tb_adder_4bit_unit;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    adder_4bit_unit_if bus ();

    adder_4bit_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef ADDER_4BIT_STATS_EN
    int exp_ops;
    int exp_carries;
`endif

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drive operands on the falling edge, then let the combinational path settle.
    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic cin, input logic en);
        @(negedge clk);
        bus.a   = a;
        bus.b   = b;
        bus.cin = cin;
        bus.en  = en;
        #1;
    endtask

    // Advance to just after the next rising edge, tracking the statistics model.
    task automatic tick();
`ifdef ADDER_4BIT_STATS_EN
        logic [4:0] r;
        r = {1'b0, bus.a} + {1'b0, bus.b} + {4'b0, bus.cin};
`endif
        @(posedge clk);
`ifdef ADDER_4BIT_STATS_EN
        if (rst_n && bus.en === 1'b1) begin
            exp_ops++;
            if (r[4]) exp_carries++;
        end
`endif
        #1;
    endtask

    task automatic check_regs(input string tag, input logic [3:0] s, input logic co,
                              input logic z, input logic o, input logic v);
        check({tag, ".sum_q"},   {12'h0, bus.sum_q},   {12'h0, s});
        check({tag, ".cout_q"},  {15'h0, bus.cout_q},  {15'h0, co});
        check({tag, ".zero_q"},  {15'h0, bus.zero_q},  {15'h0, z});
        check({tag, ".ovf_q"},   {15'h0, bus.ovf_q},   {15'h0, o});
        check({tag, ".valid_q"}, {15'h0, bus.valid_q}, {15'h0, v});
    endtask

    initial begin
        logic [3:0] ra;
        logic [3:0] rb;
        logic       rc;
        logic [4:0] e;
        logic       e_ovf;

        checks   = 0;
        failures = 0;
`ifdef ADDER_4BIT_STATS_EN
        exp_ops     = 0;
        exp_carries = 0;
`endif
        rst_n   = 1'b0;
        bus.a   = 4'h0;
        bus.b   = 4'h0;
        bus.cin = 1'b0;
        bus.en  = 1'b0;

        // Reset state, with clock running.
        repeat (2) @(posedge clk);
        #1;
        check_regs("reset", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        // 0 + 0 + 0.
        drive(4'h0, 4'h0, 1'b0, 1'b1);
        rst_n = 1'b1;
        check("zero.comb", {11'h0, bus.cout, bus.sum}, 16'h0000);
        tick();
        check_regs("zero", 4'h0, 1'b0, 1'b1, 1'b0, 1'b1);

        // F + F + 0 = 0x1E, -1 + -1 = -2 has no signed overflow.
        drive(4'hF, 4'hF, 1'b0, 1'b1);
        check("ff0.comb", {11'h0, bus.cout, bus.sum}, 16'h001E);
        tick();
        check_regs("ff0", 4'hE, 1'b1, 1'b0, 1'b0, 1'b1);

        // F + 1 + 0 = 0x10, carry ripples through every cell.
        drive(4'hF, 4'h1, 1'b0, 1'b1);
        check("f10.comb", {11'h0, bus.cout, bus.sum}, 16'h0010);
        tick();
        check_regs("f10", 4'h0, 1'b1, 1'b1, 1'b0, 1'b1);

        // F + F + 1 = 0x1F, maximum result.
        drive(4'hF, 4'hF, 1'b1, 1'b1);
        check("ff1.comb", {11'h0, bus.cout, bus.sum}, 16'h001F);
        tick();
        check_regs("ff1", 4'hF, 1'b1, 1'b0, 1'b0, 1'b1);

        // 7 + 1 = 8: positive overflow.
        drive(4'h7, 4'h1, 1'b0, 1'b1);
        check("71.comb", {11'h0, bus.cout, bus.sum}, 16'h0008);
        tick();
        check_regs("71", 4'h8, 1'b0, 1'b0, 1'b1, 1'b1);

        // en=0 with new inputs: registers hold, valid drops, comb follows.
        drive(4'h3, 4'h4, 1'b0, 1'b0);
        check("hold.comb", {11'h0, bus.cout, bus.sum}, 16'h0007);
        tick();
        check_regs("hold", 4'h8, 1'b0, 1'b0, 1'b1, 1'b0);

        // en=0 with unknown operands: nothing unknown reaches the registers.
        drive(4'bxxxx, 4'bxxxx, 1'bx, 1'b0);
        tick();
        check_regs("holdx", 4'h8, 1'b0, 1'b0, 1'b1, 1'b0);

        // Random operands against the bench's own arithmetic.
        for (int n = 0; n < 16; n++) begin
            ra    = 4'($urandom_range(0, 15));
            rb    = 4'($urandom_range(0, 15));
            rc    = 1'($urandom_range(0, 1));
            e     = {1'b0, ra} + {1'b0, rb} + {4'b0, rc};
            e_ovf = (ra[3] == rb[3]) && (e[3] != ra[3]);
            drive(ra, rb, rc, 1'b1);
            check($sformatf("rnd%0d.comb", n), {11'h0, bus.cout, bus.sum}, {11'h0, e});
            tick();
            check_regs($sformatf("rnd%0d", n), e[3:0], e[4], (e[3:0] == 4'h0), e_ovf, 1'b1);
        end

        // Known nonzero state, then asynchronous reset between edges.
        drive(4'h9, 4'h9, 1'b0, 1'b1);
        tick();
        check_regs("pre_rst", 4'h2, 1'b1, 1'b0, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_regs("async_rst", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef ADDER_4BIT_STATS_EN
        exp_ops     = 0;
        exp_carries = 0;
        check("stats.op_rst",    bus.op_cnt,    16'h0000);
        check("stats.carry_rst", bus.carry_cnt, 16'h0000);
`endif

        // Release reset with en=1: first capture is the next rising edge.
        drive(4'h2, 4'h3, 1'b0, 1'b1);
        rst_n = 1'b1;
        tick();
        check_regs("post_rst", 4'h5, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(4'hC, 4'h5, 1'b1, 1'b1);
        tick();
        check_regs("post_rst2", 4'h2, 1'b1, 1'b0, 1'b0, 1'b1);

`ifdef ADDER_4BIT_STATS_EN
        check("stats.op",    bus.op_cnt,    16'(exp_ops));
        check("stats.carry", bus.carry_cnt, 16'(exp_carries));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
